// File: rtl/rename_sequencer.sv
// Rename sequencer: allocates ROB tags at dispatch, retires them in order at commit,
// and drives map-table rename writes and commit-time clears, including a one-cycle flush.
module rename_sequencer #(
  parameter int ROBsize      = 8,
  parameter int mapValueSize = $clog2(ROBsize+1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dispatch_valid_i,
  input  logic                          dispatch_regWrite_i,
  input  logic [4:0]                    dispatch_rd_i,
  output logic                          dispatch_ready_o,
  output logic [mapValueSize-1:0]       dispatch_tag_o,
  input  logic                          commit_valid_i,
  output logic [mapValueSize-1:0]       commit_tag_o,
  input  logic                          flush_i,
  output logic [4:0]                    decodeWriteAddr_o,
  output logic [mapValueSize-1:0]       decodeWriteData_o,
  output logic                          decodeRegWrite_o,
  output logic [4:0]                    commitReadAddr_o,
  input  logic [mapValueSize-1:0]       commitReadData_i,
  output logic [31:0]                   resets_o,
  output logic [$clog2(ROBsize+1)-1:0]  count_o
);

  localparam int CW    = $clog2(ROBsize+1);
  localparam int DEPTH = 2**mapValueSize;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                  state, state_next;
  logic [mapValueSize-1:0] head, tail;
  logic [CW-1:0]           count;
  // Entry table indexed directly by tag; slot 0 is never allocated.
  logic [4:0]              ent_rd [DEPTH];
  logic                    ent_w  [DEPTH];

  logic       not_empty, full, disp_fire, commit_fire, head_w;
  logic [4:0] head_rd;

  function automatic logic [mapValueSize-1:0] tag_inc(input logic [mapValueSize-1:0] t);
    return (t == mapValueSize'(ROBsize)) ? mapValueSize'(1) : t + mapValueSize'(1);
  endfunction

  assign not_empty        = (count != '0);
  assign full             = (count == CW'(ROBsize));
  assign dispatch_ready_o = (state == RUN) && !full && !flush_i;
  assign disp_fire        = dispatch_valid_i && dispatch_ready_o;
  assign commit_fire      = commit_valid_i && not_empty && (state == RUN) && !flush_i;
  assign head_rd          = ent_rd[head];
  assign head_w           = ent_w[head];
  assign commitReadAddr_o = not_empty ? head_rd : 5'd31;
  assign dispatch_tag_o   = tail;
  assign commit_tag_o     = head;
  assign count_o          = count;

  // Idle write port parks on r31 so the map table's address match never hides a clear.
  always_comb begin
    decodeRegWrite_o  = 1'b0;
    decodeWriteAddr_o = 5'd31;
    decodeWriteData_o = '0;
    if (disp_fire && dispatch_regWrite_i && (dispatch_rd_i != 5'd31)) begin
      decodeRegWrite_o  = 1'b1;
      decodeWriteAddr_o = dispatch_rd_i;
      decodeWriteData_o = tail;
    end
  end

  // A clear only applies if the map still points at this tag (no younger writer).
  always_comb begin
    resets_o = '0;
    if (state == FLUSH) begin
      resets_o = 32'hFFFF_FFFF;
    end else if (commit_fire && head_w && (head_rd != 5'd31) && (commitReadData_i == head)) begin
      resets_o[head_rd] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     state_next = flush_i ? FLUSH : RUN;
      FLUSH:   state_next = flush_i ? FLUSH : RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      head  <= mapValueSize'(1);
      tail  <= mapValueSize'(1);
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i] <= '0;
        ent_w[i]  <= 1'b0;
      end
    end else begin
      state <= state_next;
      if (state == FLUSH) begin
        head  <= mapValueSize'(1);
        tail  <= mapValueSize'(1);
        count <= '0;
      end else begin
        if (disp_fire) begin
          ent_rd[tail] <= dispatch_rd_i;
          ent_w[tail]  <= dispatch_regWrite_i;
          tail         <= tag_inc(tail);
        end
        if (commit_fire) begin
          head <= tag_inc(head);
        end
        case ({disp_fire, commit_fire})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rename_sequencer.sv
// Bench for rename_sequencer: queue-based ROB model plus a 32-entry map-table model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rename_sequencer;

  localparam int ROB = 8;
  localparam int MV  = 4;
  localparam int CW  = 4;

  logic          clk;
  logic          reset;
  logic          dispatch_valid_i, dispatch_regWrite_i;
  logic [4:0]    dispatch_rd_i;
  logic          dispatch_ready_o;
  logic [MV-1:0] dispatch_tag_o, commit_tag_o;
  logic          commit_valid_i, flush_i;
  logic [4:0]    decodeWriteAddr_o;
  logic [MV-1:0] decodeWriteData_o;
  logic          decodeRegWrite_o;
  logic [4:0]    commitReadAddr_o;
  logic [MV-1:0] commitReadData_i;
  logic [31:0]   resets_o;
  logic [CW-1:0] count_o;

  rename_sequencer #(.ROBsize(ROB), .mapValueSize(MV)) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_regWrite_i(dispatch_regWrite_i),
    .dispatch_rd_i(dispatch_rd_i), .dispatch_ready_o(dispatch_ready_o),
    .dispatch_tag_o(dispatch_tag_o), .commit_valid_i(commit_valid_i),
    .commit_tag_o(commit_tag_o), .flush_i(flush_i),
    .decodeWriteAddr_o(decodeWriteAddr_o), .decodeWriteData_o(decodeWriteData_o),
    .decodeRegWrite_o(decodeRegWrite_o), .commitReadAddr_o(commitReadAddr_o),
    .commitReadData_i(commitReadData_i), .resets_o(resets_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic w; } ent_t;

  ent_t q[$];
  int   m_head;
  bit   m_fl;
  int   map_m [32];
  int   checks = 0;
  int   failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic int m_tail();
    return ((m_head - 1 + q.size()) % ROB) + 1;
  endfunction

  task automatic do_reset();
    dispatch_valid_i = 0; dispatch_regWrite_i = 0; dispatch_rd_i = 0;
    commit_valid_i = 0; flush_i = 0; commitReadData_i = 0;
    #1 reset = 1'b1;
    #1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_ready", 32'(dispatch_ready_o), 1);
    chk("rst_dtag", 32'(dispatch_tag_o), 1);
    chk("rst_ctag", 32'(commit_tag_o), 1);
    chk("rst_dwe", 32'(decodeRegWrite_o), 0);
    chk("rst_daddr", 32'(decodeWriteAddr_o), 31);
    chk("rst_ddata", 32'(decodeWriteData_o), 0);
    chk("rst_resets", resets_o, 0);
    chk("rst_craddr", 32'(commitReadAddr_o), 31);
    #1 reset = 1'b0;
    q.delete();
    m_head = 1;
    m_fl = 0;
    for (int r = 0; r < 32; r++) map_m[r] = 0;
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model.
  // crd < 0 feeds commitReadData_i from the modelled map table.
  task automatic cyc(input bit dv, input bit drw, input logic [4:0] drd,
                     input bit cv, input bit fl, input int crd);
    bit          e_ready, e_dfire, e_cfire, e_dw;
    logic [4:0]  e_cra;
    logic [31:0] e_res;
    int          tl;
    @(negedge clk);
    tl = m_tail();
    e_cra = (q.size() > 0) ? q[0].rd : 5'd31;
    dispatch_valid_i = dv; dispatch_regWrite_i = drw; dispatch_rd_i = drd;
    commit_valid_i = cv; flush_i = fl;
    commitReadData_i = (crd < 0) ? MV'(map_m[e_cra]) : MV'(crd);
    #1;
    e_ready = !m_fl && (q.size() < ROB) && !fl;
    e_dfire = dv && e_ready;
    e_dw    = e_dfire && drw && (drd != 5'd31);
    e_cfire = cv && (q.size() > 0) && !m_fl && !fl;
    e_res   = '0;
    if (m_fl) e_res = 32'hFFFF_FFFF;
    else if (e_cfire && q[0].w && q[0].rd != 5'd31 && int'(commitReadData_i) == m_head)
      e_res = 32'h1 << q[0].rd;
    chk("ready", 32'(dispatch_ready_o), 32'(e_ready));
    chk("dwe", 32'(decodeRegWrite_o), 32'(e_dw));
    chk("daddr", 32'(decodeWriteAddr_o), e_dw ? 32'(drd) : 31);
    chk("ddata", 32'(decodeWriteData_o), e_dw ? 32'(tl) : 0);
    chk("craddr", 32'(commitReadAddr_o), 32'(e_cra));
    chk("resets", resets_o, e_res);
    chk("dtag", 32'(dispatch_tag_o), 32'(tl));
    chk("ctag", 32'(commit_tag_o), 32'(m_head));
    chk("count", 32'(count_o), 32'(q.size()));
    for (int r = 0; r < 32; r++)
      if (e_res[r] && !(e_dw && int'(drd) == r)) map_m[r] = 0;
    if (e_dw) map_m[drd] = tl;
    if (m_fl) begin
      q.delete();
      m_head = 1;
      m_fl = fl;
    end else if (fl) begin
      m_fl = 1;
    end else begin
      if (e_cfire) begin
        void'(q.pop_front());
        m_head = (m_head % ROB) + 1;
      end
      if (e_dfire) q.push_back('{rd: drd, w: drw});
    end
  endtask

  initial begin
    reset = 1'b0;
    do_reset();

    // Rename write on dispatch, then second tag and count.
    cyc(1, 1, 5'd5, 0, 0, -1);
    chk("d1_dwe", 32'(decodeRegWrite_o), 1);
    chk("d1_daddr", 32'(decodeWriteAddr_o), 5);
    chk("d1_ddata", 32'(decodeWriteData_o), 1);
    cyc(1, 1, 5'd7, 0, 0, -1);
    chk("d2_dtag", 32'(dispatch_tag_o), 2);
    cyc(0, 0, 5'd0, 0, 0, -1);
    chk("d2_count", 32'(count_o), 2);

    // Commit clear with a matching map value, then with a stale one.
    do_reset();
    cyc(1, 1, 5'd5, 0, 0, -1);
    cyc(0, 0, 5'd0, 1, 0, 1);
    chk("c_match", resets_o, 32'h20);
    do_reset();
    cyc(1, 1, 5'd5, 0, 0, -1);
    cyc(0, 0, 5'd0, 1, 0, 3);
    chk("c_stale", resets_o, 32'h0);

    // Same-cycle dispatch and commit to r6.
    do_reset();
    cyc(1, 1, 5'd6, 0, 0, -1);
    cyc(1, 1, 5'd6, 1, 0, -1);
    chk("s_daddr", 32'(decodeWriteAddr_o), 6);
    chk("s_res", resets_o, 32'h40);
    cyc(0, 0, 5'd0, 0, 0, -1);
    chk("s_count", 32'(count_o), 1);
    chk("s_map6", 32'(map_m[6]), 2);

    // Fill to capacity, refused dispatch, wrap.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 1, 5'(i), 0, 0, -1);
    cyc(1, 1, 5'd9, 0, 0, -1);
    chk("f_count", 32'(count_o), 8);
    chk("f_ready", 32'(dispatch_ready_o), 0);
    chk("f_dwe", 32'(decodeRegWrite_o), 0);
    cyc(0, 0, 5'd0, 1, 0, -1);
    cyc(1, 1, 5'd3, 0, 0, -1);
    chk("f_wrap_tag", 32'(decodeWriteData_o), 1);
    chk("f_ctag", 32'(commit_tag_o), 2);

    // Flush with five in flight.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 1, 5'(i + 1), 0, 0, -1);
    cyc(1, 1, 5'd9, 1, 1, -1);
    chk("fl_ready", 32'(dispatch_ready_o), 0);
    cyc(1, 1, 5'd9, 0, 0, -1);
    chk("fl_res", resets_o, 32'hFFFF_FFFF);
    chk("fl_dwe", 32'(decodeRegWrite_o), 0);
    cyc(0, 0, 5'd0, 0, 0, -1);
    chk("fl_count", 32'(count_o), 0);
    chk("fl_tags", {16'(dispatch_tag_o), 16'(commit_tag_o)}, 32'h0001_0001);
    chk("fl_ready2", 32'(dispatch_ready_o), 1);

    // Async reset between edges with three in flight (checked inside do_reset).
    for (int i = 0; i < 3; i++) cyc(1, 1, 5'(i + 10), 0, 0, -1);
    do_reset();

    // Randomized traffic with varying dispatch pressure.
    for (int n = 0; n < 3000; n++) begin
      int  lvl;
      bit  dv, drw, cv, fl;
      logic [4:0] drd;
      int  crd;
      lvl = (n / 250) % 3;
      dv  = $urandom_range(0, 3) < (lvl + 1);
      drw = $urandom_range(0, 3) != 0;
      drd = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      cv  = $urandom_range(0, 3) < (3 - lvl);
      fl  = $urandom_range(0, 50) == 0;
      crd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
      cyc(dv, drw, drd, cv, fl, crd);
      if ($urandom_range(0, 400) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
